// File: rtl/alu_pkg.sv
// Shared opcode, enable and width definitions for the ALU logic-slice controller.
`timescale 1ns/1ps
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_XOR = 3'd0,
    OP_OR  = 3'd1,
    OP_AND = 3'd2,
    OP_NOT = 3'd3
  } alu_op_e;

  typedef struct packed {
    logic en_not;
    logic en_and;
    logic en_or;
    logic en_xor;
  } alu_en_t;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational opcode-to-enable decode; opcodes outside 0-3 flag illegal with no enable.
`timescale 1ns/1ps
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output alu_en_t         en,
  output logic            illegal
);

  always_comb begin
    en      = '0;
    illegal = 1'b0;
    case (op)
      OP_XOR:  en.en_xor = 1'b1;
      OP_OR:   en.en_or  = 1'b1;
      OP_AND:  en.en_and = 1'b1;
      OP_NOT:  en.en_not = 1'b1;
      default: illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_logic_ctrl.sv
// Decode-at-accept FIFO between the issue stage and the logic slice.
// Optional macro ALU_LOGIC_CTRL_ERRCNT_EN adds a saturating err_count of accepted illegal opcodes.
`timescale 1ns/1ps
module alu_logic_ctrl
  import alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_a,
  output logic [N-1:0]    out_b,
  output logic            enable_xor,
  output logic            enable_or,
  output logic            enable_and,
  output logic            enable_not,
  output logic            out_illegal
`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
  ,
  output logic [7:0]      err_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    alu_en_t     en;
    logic        illegal;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  alu_en_t            dec_en;
  logic               dec_illegal;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  alu_op_decode u_decode (
    .op      (in_op),
    .en      (dec_en),
    .illegal (dec_illegal)
  );

  // Handshake flags depend only on registered count, never on out_ready.
  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry = '{en: dec_en, illegal: dec_illegal, a: in_a, b: in_b};

  // Storage carries no reset; stale entries are hidden by count and the output gating.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == PTR_W'(gi)) begin
          mem[gi] <= wr_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_entry = mem[rd_ptr_reg];

  always_comb begin
    out_a       = '0;
    out_b       = '0;
    enable_xor  = 1'b0;
    enable_or   = 1'b0;
    enable_and  = 1'b0;
    enable_not  = 1'b0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_a       = rd_entry.a;
      out_b       = rd_entry.b;
      enable_xor  = rd_entry.en.en_xor;
      enable_or   = rd_entry.en.en_or;
      enable_and  = rd_entry.en.en_and;
      enable_not  = rd_entry.en.en_not;
      out_illegal = rd_entry.illegal;
    end
  end

`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
  logic [7:0] err_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg <= '0;
    end else if (push && dec_illegal && err_count_reg != 8'hFF) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_alu_logic_ctrl.sv
// Randomized self-checking bench for alu_logic_ctrl against a queue-based transaction model.
`timescale 1ns/1ps
module tb_alu_logic_ctrl;

  localparam int N     = 8;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
  logic         enable_xor;
  logic         enable_or;
  logic         enable_and;
  logic         enable_not;
  logic         out_illegal;
`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
  logic [7:0]   err_count;
`endif

  alu_logic_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .enable_xor  (enable_xor),
    .enable_or   (enable_or),
    .enable_and  (enable_and),
    .enable_not  (enable_not),
    .out_illegal (out_illegal)
`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } txn_t;

  txn_t q[$];
  int   model_err = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2*N+6:0] obs;
  assign obs = {in_ready, out_valid, out_illegal, enable_not, enable_and,
                enable_or, enable_xor, out_a, out_b};

  // Expected visible state from the model: head of queue or all-zero when empty.
  function automatic logic [2*N+6:0] exp_word();
    logic [2:0] op;
    if (q.size() == 0) return {1'b1, 1'b0, 5'b0, {N{1'b0}}, {N{1'b0}}};
    op = q[0].op;
    return {q.size() != DEPTH, 1'b1, op >= 3'd4, op == 3'd3, op == 3'd2,
            op == 3'd1, op == 3'd0, q[0].a, q[0].b};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic rdy);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
  endtask

  task automatic drive_rand(input logic v, input logic rdy);
    drive(v, 3'($urandom_range(0, 7)), N'($urandom), N'($urandom), rdy);
  endtask

  // Advance one clock edge and apply the handshake rules to the model queue.
  task automatic clock_step();
    bit   acc, con;
    txn_t t;
    acc  = in_valid && (q.size() < DEPTH);
    con  = out_ready && (q.size() > 0);
    t.op = in_op;
    t.a  = in_a;
    t.b  = in_b;
    @(posedge clk);
    #1;
    if (con) begin
      $display("pop  op=%0d a=%h b=%h", q[0].op, q[0].a, q[0].b);
      void'(q.pop_front());
    end
    if (acc) begin
      $display("push op=%0d a=%h b=%h", t.op, t.a, t.b);
      q.push_back(t);
      if (t.op >= 3'd4 && model_err < 255) model_err++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_rand(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, exp_word());
    end
`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_err_count: got %0d expected 0", err_count);
    end
`endif
    rst = 1'b0;
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    clock_step();
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected %h", obs, exp_word());
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b1);
    clock_step();
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    checks++;
    if ({out_valid, enable_or, enable_xor, enable_and, enable_not, out_illegal, out_a, out_b}
        !== {1'b1, 1'b1, 4'b0, 8'hF0, 8'h0F}) begin
      errors++;
      $display("FAIL basic_or: got v=%b or=%b xor=%b and=%b not=%b ill=%b a=%h b=%h required v=1 or=1 others 0 a=f0 b=0f",
               out_valid, enable_or, enable_xor, enable_and, enable_not, out_illegal, out_a, out_b);
    end
    clock_step();
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL basic_drain: got %h expected %h", obs, exp_word());
    end
  endtask

  task automatic test_full();
    drive(1'b1, 3'd0, N'($urandom), N'($urandom), 1'b0);
    clock_step();
    drive(1'b1, 3'd2, N'($urandom), N'($urandom), 1'b0);
    clock_step();
    checks++;
    if (in_ready !== 1'b0 || enable_xor !== 1'b1) begin
      errors++;
      $display("FAIL full_in_ready: got in_ready=%b xor=%b required in_ready=0 xor=1", in_ready, enable_xor);
    end
    drive(1'b1, 3'd3, N'($urandom), N'($urandom), 1'b0);
    clock_step();
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL full_third_rejected: got %h expected %h", obs, exp_word());
    end
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    clock_step();
    checks++;
    if (enable_and !== 1'b1 || obs !== exp_word()) begin
      errors++;
      $display("FAIL full_order_and: got %h expected %h", obs, exp_word());
    end
    clock_step();
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL full_drain: got %h expected %h", obs, exp_word());
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'd5, N'($urandom), N'($urandom), 1'b1);
    clock_step();
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    checks++;
    if (out_illegal !== 1'b1 || {enable_xor, enable_or, enable_and, enable_not} !== 4'b0
        || obs !== exp_word()) begin
      errors++;
      $display("FAIL illegal_op5: got %h expected %h", obs, exp_word());
    end
`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
    checks++;
    if (err_count !== 8'(model_err)) begin
      errors++;
      $display("FAIL illegal_err_count: got %0d expected %0d", err_count, model_err);
    end
`endif
    clock_step();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 3'($urandom_range(4, 7)), N'($urandom), N'($urandom), 1'b1);
      clock_step();
      checks++;
      if (obs !== exp_word()) begin
        errors++;
        $display("FAIL illegal_stream[%0d]: got %h expected %h", i, obs, exp_word());
      end
    end
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    repeat (2) clock_step();
`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
    checks++;
    if (err_count !== 8'd255 || model_err != 255) begin
      errors++;
      $display("FAIL illegal_saturate: got %0d expected 255", err_count);
    end
`endif
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL illegal_drain: got %h expected %h", obs, exp_word());
    end
  endtask

  task automatic test_back_to_back();
    drive_rand(1'b1, 1'b0);
    clock_step();
    for (int i = 0; i < 20; i++) begin
      drive_rand(1'b1, 1'b1);
      clock_step();
      checks++;
      if (q.size() != 1 || out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== exp_word()) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, obs, exp_word());
      end
    end
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    clock_step();
  endtask

  task automatic test_async_reset();
    drive_rand(1'b1, 1'b0);
    clock_step();
    drive_rand(1'b1, 1'b0);
    clock_step();
    checks++;
    if (obs !== exp_word() || q.size() != 2) begin
      errors++;
      $display("FAIL async_prefill: got %h expected %h", obs, exp_word());
    end
    #2 rst = 1'b1;
    #1;
    q.delete();
    model_err = 0;
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h expected %h", obs, exp_word());
    end
`ifdef ALU_LOGIC_CTRL_ERRCNT_EN
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_err_count: got %0d expected 0", err_count);
    end
`endif
    #2 rst = 1'b0;
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    clock_step();
    checks++;
    if (obs !== exp_word()) begin
      errors++;
      $display("FAIL async_reset_after: got %h expected %h", obs, exp_word());
    end
  endtask

  task automatic test_stall();
    drive_rand(1'b1, 1'b0);
    clock_step();
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'(i % 2), 1'b0);
      clock_step();
      checks++;
      if (obs !== exp_word()) begin
        errors++;
        $display("FAIL stall[%0d]: got %h expected %h", i, obs, exp_word());
      end
    end
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    repeat (2) clock_step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      clock_step();
      checks++;
      if (obs !== exp_word()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_word());
      end
    end
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    repeat (DEPTH) clock_step();
    checks++;
    if (obs !== exp_word() || q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %h expected %h", obs, exp_word());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
